pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/mdu_timer.sv | 73 +++++++
 rtl/pipeline_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared MDU state encoding, default latencies and counter-width helper
// for the pipeline hazard controller.
`default_nettype none

package hazard_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_W       = 16;

  // Down-counter width: enough for the longer latency, never below one bit.
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_timer.sv
// mdu_timer: IDLE/BUSY scoreboard for the multi-cycle multiply/divide unit.
// busy_o spans the whole op latency; done_o marks its last busy cycle.
`default_nettype none

module mdu_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  mdu_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  load_val;
  logic           busy_q;
  logic           done_q;

  assign load_val = is_div_i ? DIV_LOAD : MULT_LOAD;

  // done_q is set one edge early (when the count reaches 1) so it lines up
  // with the cycle in which the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            state_q <= MDU_BUSY;
            cnt_q   <= load_val;
            busy_q  <= 1'b1;
            done_q  <= (load_val == '0);
          end
        end
        MDU_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CW'(1));
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / MDU stall, branch flush and stall counter.
// MDU scoreboard is built only when PIPELINE_HAZARD_MDU_EN is defined.
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesMdu,
  input  logic             BranchTaken,
  input  logic             ID_EX_MduStart,
  input  logic             ID_EX_MduIsDiv,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             load_use;
  logic             mdu_stall;
  logic             stall;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

`ifdef PIPELINE_HAZARD_MDU_EN
  mdu_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (ID_EX_MduStart),
    .is_div_i (ID_EX_MduIsDiv),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done)
  );

  assign mdu_stall = mdu_busy && IF_ID_UsesMdu;
`else
  logic unused_mdu;

  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_stall  = 1'b0;
  assign unused_mdu = ^{ID_EX_MduStart, ID_EX_MduIsDiv, IF_ID_UsesMdu,
                        (MULT_CYCLES > 0), (DIV_CYCLES > 0)};
`endif

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                     (ID_EX_RegisterRt == IF_ID_RegisterRt));

  assign stall        = load_use || mdu_stall;
  assign PCWrite      = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  // Branch operands are stale while stalled; the branch resolves again next cycle.
  assign IF_ID_Flush  = BranchTaken && !stall;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl (CNT_W=4).
// MDU scenarios are compiled when PIPELINE_HAZARD_MDU_EN is defined.
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRt;
  logic [4:0] IF_ID_RegisterRs;
  logic [4:0] IF_ID_RegisterRt;
  logic       IF_ID_UsesMdu;
  logic       BranchTaken;
  logic       ID_EX_MduStart;
  logic       ID_EX_MduIsDiv;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       ID_EX_Bubble;
  logic       IF_ID_Flush;
  logic       mdu_busy;
  logic       mdu_done;
  logic [3:0] stall_cycles;

  typedef struct {
    logic       stall;
    logic       flush;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] model_cnt;
  int         errors;
  int         checks;

  pipeline_hazard_ctrl #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (32),
    .CNT_W       (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .IF_ID_UsesMdu    (IF_ID_UsesMdu),
    .BranchTaken      (BranchTaken),
    .ID_EX_MduStart   (ID_EX_MduStart),
    .ID_EX_MduIsDiv   (ID_EX_MduIsDiv),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .IF_ID_Flush      (IF_ID_Flush),
    .mdu_busy         (mdu_busy),
    .mdu_done         (mdu_done),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus and queues the expected outputs for that cycle.
  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic st,
                       input logic dv, input logic um, input logic e_stall,
                       input logic e_flush, input logic e_busy, input logic e_done,
                       input string nm);
    exp_t x;
    @(posedge clk); #1;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = ert;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    BranchTaken      = br;
    ID_EX_MduStart   = st;
    ID_EX_MduIsDiv   = dv;
    IF_ID_UsesMdu    = um;
    x.stall = e_stall;
    x.flush = e_flush;
    x.busy  = e_busy;
    x.done  = e_done;
    x.cnt   = model_cnt;
    x.name  = nm;
    sb.push_back(x);
    if (e_stall && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    BranchTaken = 0; ID_EX_MduStart = 0; ID_EX_MduIsDiv = 0; IF_ID_UsesMdu = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 4'd0;
    sb.delete();
  endtask

  task automatic test_reset;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_idle");
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b1100) begin
      errors++; $display("FAIL %s ctl got %b exp 1100", e.name, {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush});
    end
    checks++;
    if (stall_cycles !== e.cnt) begin
      errors++; $display("FAIL %s stall_cycles got %0d exp %0d", e.name, stall_cycles, e.cnt);
    end
    checks++;
    if ({mdu_busy, mdu_done} !== {e.busy, e.done}) begin
      errors++; $display("FAIL %s mdu got %b exp %b", e.name, {mdu_busy, mdu_done}, {e.busy, e.done});
    end
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1, 8, 8, 3, 0, 0, 0, 0, 1, 0, 0, 0, "lu_rs");
        1: drive(0, 8, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, "lu_cleared");
        2: drive(1, 9, 2, 9, 0, 0, 0, 0, 1, 0, 0, 0, "lu_rt");
        3: drive(1, 9, 8, 7, 0, 0, 0, 0, 0, 0, 0, 0, "lu_nomatch");
        4: drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "lu_rt_zero");
        default: drive(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, "lu_no_memread");
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== {!e.stall, !e.stall, e.stall}) begin
        errors++; $display("FAIL %s ctl got %b exp %b", e.name, {PCWrite, IF_ID_Write, ID_EX_Bubble}, {!e.stall, !e.stall, e.stall});
      end
      checks++;
      if (IF_ID_Flush !== e.flush) begin
        errors++; $display("FAIL %s flush got %b exp %b", e.name, IF_ID_Flush, e.flush);
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++; $display("FAIL %s stall_cycles got %0d exp %0d", e.name, stall_cycles, e.cnt);
      end
    end
  endtask

  task automatic test_branch;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 5, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, "br_during_stall");
        1: drive(0, 5, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, "br_after_stall");
        2: drive(0, 0, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0, "br_not_taken");
        default: drive(1, 7, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, "br_load_no_dep");
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== {!e.stall, !e.stall, e.stall}) begin
        errors++; $display("FAIL %s ctl got %b exp %b", e.name, {PCWrite, IF_ID_Write, ID_EX_Bubble}, {!e.stall, !e.stall, e.stall});
      end
      checks++;
      if (IF_ID_Flush !== e.flush) begin
        errors++; $display("FAIL %s flush got %b exp %b", e.name, IF_ID_Flush, e.flush);
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++; $display("FAIL %s stall_cycles got %0d exp %0d", e.name, stall_cycles, e.cnt);
      end
    end
  endtask

`ifdef PIPELINE_HAZARD_MDU_EN
  task automatic test_mdu_divide;
    for (int i = 0; i <= 33; i++) begin
      if (i == 0)       drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "div_start");
      else if (i <= 32) drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, (i == 32), "div_busy");
      else              drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "div_issue");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== {!e.stall, !e.stall, e.stall}) begin
        errors++; $display("FAIL %s cyc %0d ctl got %b exp %b", e.name, i, {PCWrite, IF_ID_Write, ID_EX_Bubble}, {!e.stall, !e.stall, e.stall});
      end
      checks++;
      if ({mdu_busy, mdu_done} !== {e.busy, e.done}) begin
        errors++; $display("FAIL %s cyc %0d mdu got %b exp %b", e.name, i, {mdu_busy, mdu_done}, {e.busy, e.done});
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++; $display("FAIL %s cyc %0d stall_cycles got %0d exp %0d", e.name, i, stall_cycles, e.cnt);
      end
    end
  endtask

  task automatic test_mdu_reset;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_cnt = 4'd0;
      end
      if (i == 0)      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "mul_start");
      else if (i == 1) drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "mul_busy");
      else             drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "mul_after_rst");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({mdu_busy, mdu_done} !== {e.busy, e.done}) begin
        errors++; $display("FAIL %s cyc %0d mdu got %b exp %b", e.name, i, {mdu_busy, mdu_done}, {e.busy, e.done});
      end
      checks++;
      if ({PCWrite, ID_EX_Bubble} !== {!e.stall, e.stall}) begin
        errors++; $display("FAIL %s cyc %0d ctl got %b exp %b", e.name, i, {PCWrite, ID_EX_Bubble}, {!e.stall, e.stall});
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++; $display("FAIL %s cyc %0d stall_cycles got %0d exp %0d", e.name, i, stall_cycles, e.cnt);
      end
    end
  endtask
`else
  task automatic test_mdu_ignored;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, (i == 0), 1, 1, 0, 0, 0, 0, "mdu_ignored");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b110) begin
        errors++; $display("FAIL %s cyc %0d ctl got %b exp 110", e.name, i, {PCWrite, IF_ID_Write, ID_EX_Bubble});
      end
      checks++;
      if ({mdu_busy, mdu_done} !== 2'b00) begin
        errors++; $display("FAIL %s cyc %0d mdu got %b exp 00", e.name, i, {mdu_busy, mdu_done});
      end
    end
  endtask
`endif

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) drive(1, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, "sat_stall");
      else        drive(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_hold");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++; $display("FAIL %s cyc %0d stall_cycles got %0d exp %0d", e.name, i, stall_cycles, e.cnt);
      end
      checks++;
      if (ID_EX_Bubble !== e.stall) begin
        errors++; $display("FAIL %s cyc %0d bubble got %b exp %b", e.name, i, ID_EX_Bubble, e.stall);
      end
    end
    checks++;
    if (stall_cycles !== 4'hF) begin
      errors++; $display("FAIL sat_final stall_cycles got %0d exp 15", stall_cycles);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    model_cnt = 4'd0;
    rst       = 1'b1;
    ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    BranchTaken = 0; ID_EX_MduStart = 0; ID_EX_MduIsDiv = 0; IF_ID_UsesMdu = 0;
    test_reset();
    test_load_use();
    test_branch();
`ifdef PIPELINE_HAZARD_MDU_EN
    test_mdu_divide();
    test_mdu_reset();
`else
    test_mdu_ignored();
`endif
    test_saturation();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
